// File: rtl/bitfusion_pkg.sv
// bitfusion_feeder shared types.
// FSM encoding, config field types and width helpers.
package bitfusion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  // 000=1b, 001=2b, 010=4b, 011=8b
  typedef logic [2:0] bitwidth_t;
  typedef logic [3:0] sign_t;

  localparam bitwidth_t BW_1 = 3'b000;

  // Holds t plus the largest lane offset with headroom for wrap compare.
  function automatic int t_width(int depth, int n);
    return $clog2(depth + 2 * n) + 1;
  endfunction

endpackage

// File: rtl/bitfusion_feeder_if.sv
// Host <-> feeder bus: buffer writes, start/config in,
// skewed array feed and status out.
interface bitfusion_feeder_if
  import bitfusion_pkg::*;
#(
  parameter int ARRAY_SIZE = 2,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16
) ();

  localparam int N      = ARRAY_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RW     = (N > 1) ? $clog2(N) : 1;

  logic                    start;
  logic [ADDR_W:0]         num_words;
  bitwidth_t               cfg_input_bitwidth;
  bitwidth_t               cfg_weight_bitwidth;
  sign_t [N-1:0][N-1:0]    cfg_input_sign;
  sign_t [N-1:0][N-1:0]    cfg_weight_sign;

  logic                    ibuf_wr_en;
  logic [RW-1:0]           ibuf_wr_row;
  logic [ADDR_W-1:0]       ibuf_wr_addr;
  logic [DATA_W-1:0]       ibuf_wr_data;

  logic                    wbuf_wr_en;
  logic [RW-1:0]           wbuf_wr_row;
  logic [RW-1:0]           wbuf_wr_col;
  logic [ADDR_W-1:0]       wbuf_wr_addr;
  logic [DATA_W-1:0]       wbuf_wr_data;

  logic [N-1:0][DATA_W-1:0]        IBUF;
  logic [N-1:0][N-1:0][DATA_W-1:0] WBUF;
  logic [N-1:0]                    input_rd_en;
  logic [N-1:0][N-1:0]             weight_rd_en;
  logic [N-1:0]                    acc_clear;
  bitwidth_t                       input_bitwidth;
  bitwidth_t                       weight_bitwidth;
  sign_t [N-1:0][N-1:0]            input_sign;
  sign_t [N-1:0][N-1:0]            weight_sign;
  logic                            busy;
  logic                            done;

  modport master (
    output start, num_words,
    output cfg_input_bitwidth, cfg_weight_bitwidth,
    output cfg_input_sign, cfg_weight_sign,
    output ibuf_wr_en, ibuf_wr_row, ibuf_wr_addr, ibuf_wr_data,
    output wbuf_wr_en, wbuf_wr_row, wbuf_wr_col,
    output wbuf_wr_addr, wbuf_wr_data,
    input  IBUF, WBUF, input_rd_en, weight_rd_en, acc_clear,
    input  input_bitwidth, weight_bitwidth,
    input  input_sign, weight_sign, busy, done
  );

  modport slave (
    input  start, num_words,
    input  cfg_input_bitwidth, cfg_weight_bitwidth,
    input  cfg_input_sign, cfg_weight_sign,
    input  ibuf_wr_en, ibuf_wr_row, ibuf_wr_addr, ibuf_wr_data,
    input  wbuf_wr_en, wbuf_wr_row, wbuf_wr_col,
    input  wbuf_wr_addr, wbuf_wr_data,
    output IBUF, WBUF, input_rd_en, weight_rd_en, acc_clear,
    output input_bitwidth, weight_bitwidth,
    output input_sign, weight_sign, busy, done
  );

endinterface

// File: rtl/bitfusion_lane_buf.sv
// One feeder lane: word storage, write port and the skewed
// registered read driven by the shared stream counter.
module bitfusion_lane_buf
  import bitfusion_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = 32,
  parameter int  OFFSET = 0,
  parameter int  T_W    = 6,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              stream_i,
  input  logic [T_W-1:0]    t_i,
  input  logic [ADDR_W:0]   k_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rd_en_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic              rd_en_q;
  logic              addr_ok;
  logic [T_W-1:0]    rel;
  logic              en;

  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign addr_ok = 1'b1;
  end else begin : g_part
    assign addr_ok = ({1'b0, waddr_i} < (ADDR_W+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (we_i && addr_ok) mem_q[waddr_i] <= wdata_i;
  end

  // t below OFFSET wraps far above any K, so one compare covers both bounds.
  assign rel = t_i - T_W'(OFFSET);
  assign en  = stream_i && (rel < T_W'(k_i));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      data_q  <= '0;
      rd_en_q <= 1'b0;
    end else begin
      data_q  <= en ? mem_q[rel[ADDR_W-1:0]] : '0;
      rd_en_q <= en;
    end
  end

  assign data_o  = data_q;
  assign rd_en_o = rd_en_q;

endmodule

// File: rtl/bitfusion_feeder.sv
// Sequencer feeding the bitfusion array: clear, skewed
// stream of K words per lane, drain, done.
module bitfusion_feeder
  import bitfusion_pkg::*;
#(
  parameter int ARRAY_SIZE   = 2,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               nRST,
  bitfusion_feeder_if.slave  bus
);

  localparam int N      = ARRAY_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RW     = (N > 1) ? $clog2(N) : 1;
  localparam int T_W    = t_width(DEPTH, N);
  localparam int DC_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [T_W-1:0]  SKEW    = T_W'(2 * (N - 1));
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYCLES - 1);

  feeder_state_t        state_q, state_d;
  logic [T_W-1:0]       t_q, t_d;
  logic [DC_W-1:0]      dc_q, dc_d;
  logic [ADDR_W:0]      k_q, k_d;
  bitwidth_t            ibw_q, ibw_d;
  bitwidth_t            wbw_q, wbw_d;
  sign_t [N-1:0][N-1:0] isg_q, isg_d;
  sign_t [N-1:0][N-1:0] wsg_q, wsg_d;
  logic [N-1:0]         acc_clear_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 idle;
  logic                 stream_d;
  logic [T_W-1:0]       t_last;

  assign idle     = (state_q == IDLE);
  assign stream_d = (state_d == STREAM);
  assign t_last   = T_W'(k_q) + SKEW - T_W'(1);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dc_d    = dc_q;
    k_d     = k_q;
    ibw_d   = ibw_q;
    wbw_d   = wbw_q;
    isg_d   = isg_q;
    wsg_d   = wsg_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          k_d     = bus.num_words;
          ibw_d   = bus.cfg_input_bitwidth;
          wbw_d   = bus.cfg_weight_bitwidth;
          isg_d   = bus.cfg_input_sign;
          wsg_d   = bus.cfg_weight_sign;
        end
      end
      CLEAR: begin
        t_d     = '0;
        dc_d    = '0;
        state_d = (k_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        if (t_q == t_last) begin
          t_d     = '0;
          state_d = DRAIN;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      DRAIN: begin
        if (dc_q == DC_LAST) begin
          dc_d    = '0;
          state_d = DONE;
        end else begin
          dc_d = dc_q + DC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      t_q         <= '0;
      dc_q        <= '0;
      k_q         <= '0;
      ibw_q       <= BW_1;
      wbw_q       <= BW_1;
      isg_q       <= '0;
      wsg_q       <= '0;
      acc_clear_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      dc_q        <= dc_d;
      k_q         <= k_d;
      ibw_q       <= ibw_d;
      wbw_q       <= wbw_d;
      isg_q       <= isg_d;
      wsg_q       <= wsg_d;
      acc_clear_q <= {N{state_d == CLEAR}};
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  logic [N-1:0][DATA_W-1:0]        ibuf_w;
  logic [N-1:0][N-1:0][DATA_W-1:0] wbuf_w;
  logic [N-1:0]                    in_en_w;
  logic [N-1:0][N-1:0]             wt_en_w;

  for (genvar r = 0; r < N; r++) begin : g_row
    bitfusion_lane_buf #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .OFFSET (r),
      .T_W    (T_W)
    ) u_ibuf (
      .clk      (clk),
      .nRST     (nRST),
      .we_i     (idle && bus.ibuf_wr_en &&
                 (bus.ibuf_wr_row == RW'(r))),
      .waddr_i  (bus.ibuf_wr_addr),
      .wdata_i  (bus.ibuf_wr_data),
      .stream_i (stream_d),
      .t_i      (t_d),
      .k_i      (k_q),
      .data_o   (ibuf_w[r]),
      .rd_en_o  (in_en_w[r])
    );
    for (genvar c = 0; c < N; c++) begin : g_col
      bitfusion_lane_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .OFFSET (r + c),
        .T_W    (T_W)
      ) u_wbuf (
        .clk      (clk),
        .nRST     (nRST),
        .we_i     (idle && bus.wbuf_wr_en &&
                   (bus.wbuf_wr_row == RW'(r)) &&
                   (bus.wbuf_wr_col == RW'(c))),
        .waddr_i  (bus.wbuf_wr_addr),
        .wdata_i  (bus.wbuf_wr_data),
        .stream_i (stream_d),
        .t_i      (t_d),
        .k_i      (k_q),
        .data_o   (wbuf_w[r][c]),
        .rd_en_o  (wt_en_w[r][c])
      );
    end
  end

  assign bus.IBUF            = ibuf_w;
  assign bus.WBUF            = wbuf_w;
  assign bus.input_rd_en     = in_en_w;
  assign bus.weight_rd_en    = wt_en_w;
  assign bus.acc_clear       = acc_clear_q;
  assign bus.input_bitwidth  = ibw_q;
  assign bus.weight_bitwidth = wbw_q;
  assign bus.input_sign      = isg_q;
  assign bus.weight_sign     = wsg_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_bitfusion_feeder.sv
// Directed bench for bitfusion_feeder with per-lane
// scoreboard queues of expected stream words.
module tb_bitfusion_feeder;
  import bitfusion_pkg::*;

  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int DRAIN = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = 1;
  localparam int NL    = N + N * N;
  localparam int SW    = N * N * 4;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  bitfusion_feeder_if #(
    .ARRAY_SIZE (N),
    .DATA_W     (DW),
    .DEPTH      (DEPTH)
  ) bus ();

  bitfusion_feeder #(
    .ARRAY_SIZE   (N),
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ib_m [N][DEPTH];
  logic [DW-1:0] wb_m [N][N][DEPTH];
  logic [DW-1:0] sb [NL][$];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lane_off(input int l);
    if (l < N) return l;
    return (l - N) / N + (l - N) % N;
  endfunction

  function automatic logic lane_en(input int l);
    if (l < N) return bus.input_rd_en[l];
    return bus.weight_rd_en[(l - N) / N][(l - N) % N];
  endfunction

  function automatic logic [DW-1:0] lane_dat(input int l);
    if (l < N) return bus.IBUF[l];
    return bus.WBUF[(l - N) / N][(l - N) % N];
  endfunction

  function automatic logic [DW-1:0] lane_mem(input int l, input int a);
    if (l < N) return ib_m[l][a];
    return wb_m[(l - N) / N][(l - N) % N][a];
  endfunction

  task automatic wr_i(input int r, input int a, input logic [DW-1:0] d);
    bus.ibuf_wr_en   = 1'b1;
    bus.ibuf_wr_row  = RW'(r);
    bus.ibuf_wr_addr = AW'(a);
    bus.ibuf_wr_data = d;
    @(negedge clk);
    bus.ibuf_wr_en   = 1'b0;
    ib_m[r][a] = d;
  endtask

  task automatic wr_w(input int r, input int c, input int a,
                      input logic [DW-1:0] d);
    bus.wbuf_wr_en   = 1'b1;
    bus.wbuf_wr_row  = RW'(r);
    bus.wbuf_wr_col  = RW'(c);
    bus.wbuf_wr_addr = AW'(a);
    bus.wbuf_wr_data = d;
    @(negedge clk);
    bus.wbuf_wr_en   = 1'b0;
    wb_m[r][c][a] = d;
  endtask

  // Entered on a negedge in IDLE; returns on the negedge after done.
  task automatic run_op(input int k, input bit hold, input bit lock,
                        input bit chg, input bit sw,
                        input bitwidth_t ibw, input bitwidth_t wbw,
                        input logic [SW-1:0] isg,
                        input logic [SW-1:0] wsg);
    int dc;
    dc = (k == 0) ? 2 + DRAIN : 2 + k + 2 * (N - 1) + DRAIN;
    bus.start               = 1'b1;
    bus.num_words           = (AW+1)'(k);
    bus.cfg_input_bitwidth  = ibw;
    bus.cfg_weight_bitwidth = wbw;
    bus.cfg_input_sign      = isg;
    bus.cfg_weight_sign     = wsg;
    if (sw) begin
      bus.ibuf_wr_en   = 1'b1;
      bus.ibuf_wr_row  = RW'(1);
      bus.ibuf_wr_addr = AW'(0);
      bus.ibuf_wr_data = 32'hABCD_0001;
      ib_m[1][0] = 32'hABCD_0001;
    end
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < k; a++)
        sb[l].push_back(lane_mem(l, a));
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) bus.start = 1'b0;
        bus.ibuf_wr_en = 1'b0;
      end
      if (chg && c == 2) begin
        bus.cfg_input_bitwidth  = ~ibw;
        bus.cfg_weight_bitwidth = ~wbw;
        bus.cfg_input_sign      = ~isg;
        bus.cfg_weight_sign     = ~wsg;
        bus.num_words           = ~bus.num_words;
      end
      if (lock && c == 3) begin
        bus.start        = 1'b1;
        bus.ibuf_wr_en   = 1'b1;
        bus.ibuf_wr_row  = RW'(0);
        bus.ibuf_wr_addr = AW'(0);
        bus.ibuf_wr_data = 32'hDEAD_BEEF;
        bus.wbuf_wr_en   = 1'b1;
        bus.wbuf_wr_row  = RW'(1);
        bus.wbuf_wr_col  = RW'(1);
        bus.wbuf_wr_addr = AW'(0);
        bus.wbuf_wr_data = 32'hDEAD_BEEF;
      end
      if (lock && c == 4) begin
        bus.start      = 1'b0;
        bus.ibuf_wr_en = 1'b0;
        bus.wbuf_wr_en = 1'b0;
      end
      chk($sformatf("acc_clear c%0d", c), 128'(bus.acc_clear),
          128'((c == 1) ? 2'b11 : 2'b00));
      chk($sformatf("busy c%0d", c), 128'(bus.busy),
          128'(c <= dc));
      chk($sformatf("done c%0d", c), 128'(bus.done),
          128'(c == dc));
      if (c == 1 || c == dc) begin
        chk("in_bw", 128'(bus.input_bitwidth), 128'(ibw));
        chk("wt_bw", 128'(bus.weight_bitwidth), 128'(wbw));
        chk("in_sign", 128'(bus.input_sign), 128'(isg));
        chk("wt_sign", 128'(bus.weight_sign), 128'(wsg));
      end
      for (int l = 0; l < NL; l++) begin
        int d = lane_off(l);
        bit ee = (c >= 2 + d) && (c <= 1 + d + k);
        chk($sformatf("rd_en l%0d c%0d", l, c),
            128'(lane_en(l)), 128'(ee));
        if (lane_en(l) === 1'b1) begin
          if (sb[l].size() == 0)
            chk($sformatf("sb_nonempty l%0d", l), 128'(sb[l].size()), 128'(1));
          else
            chk($sformatf("data l%0d c%0d", l, c),
                128'(lane_dat(l)), 128'(sb[l].pop_front()));
        end else begin
          chk($sformatf("idle_data l%0d c%0d", l, c),
              128'(lane_dat(l)), 128'(0));
        end
      end
    end
    for (int l = 0; l < NL; l++)
      chk($sformatf("sb_drained l%0d", l), 128'(sb[l].size()), 128'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 128'(bus.busy), 128'(0));
    chk({tag, " done"}, 128'(bus.done), 128'(0));
    chk({tag, " acc_clear"}, 128'(bus.acc_clear), 128'(0));
    chk({tag, " in_en"}, 128'(bus.input_rd_en), 128'(0));
    chk({tag, " wt_en"}, 128'(bus.weight_rd_en), 128'(0));
    chk({tag, " IBUF"}, 128'(bus.IBUF), 128'(0));
    chk({tag, " WBUF"}, 128'(bus.WBUF), 128'(0));
    chk({tag, " in_bw"}, 128'(bus.input_bitwidth), 128'(0));
    chk({tag, " wt_sign"}, 128'(bus.weight_sign), 128'(0));
  endtask

  initial begin
    bus.start               = 1'b0;
    bus.num_words           = '0;
    bus.cfg_input_bitwidth  = '0;
    bus.cfg_weight_bitwidth = '0;
    bus.cfg_input_sign      = '0;
    bus.cfg_weight_sign     = '0;
    bus.ibuf_wr_en          = 1'b0;
    bus.ibuf_wr_row         = '0;
    bus.ibuf_wr_addr        = '0;
    bus.ibuf_wr_data        = '0;
    bus.wbuf_wr_en          = 1'b0;
    bus.wbuf_wr_row         = '0;
    bus.wbuf_wr_col         = '0;
    bus.wbuf_wr_addr        = '0;
    bus.wbuf_wr_data        = '0;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    nRST = 1'b1;
    @(negedge clk);

    // Basic K=1 with uniform data
    for (int r = 0; r < N; r++) wr_i(r, 0, 32'h5555_5555);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, 0, 32'h5555_5555);
    run_op(1, 0, 0, 0, 0, 3'b011, 3'b010, 16'h1234, 16'h8421);

    // Ordering K=3, config changed after start
    for (int a = 0; a < 3; a++) begin
      wr_i(0, a, 32'(1 + a));
      wr_i(1, a, 32'(4 + a));
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int a = 0; a < 3; a++)
          wr_w(r, c, a, 32'h10 * 32'(r * N + c + 1) + 32'(a));
    run_op(3, 0, 0, 1, 0, 3'b001, 3'b000, 16'hA5C3, 16'h0F0F);

    // K=0
    run_op(0, 0, 0, 0, 0, 3'b010, 3'b011, 16'h0001, 16'h8000);

    // Lockout: start and writes while busy are ignored
    run_op(2, 0, 1, 1, 0, 3'b001, 3'b010, 16'h5A5A, 16'hC0DE);
    run_op(2, 0, 0, 0, 0, 3'b001, 3'b010, 16'h5A5A, 16'hC0DE);

    // Back-to-back with start held
    run_op(1, 1, 0, 0, 0, 3'b011, 3'b011, 16'hFFFF, 16'h0000);
    run_op(2, 0, 0, 0, 0, 3'b000, 3'b001, 16'h1111, 16'h2222);

    // Reset mid-stream, then restart on retained buffers
    bus.start     = 1'b1;
    bus.num_words = (AW+1)'(3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_pre_rst", 128'(bus.busy), 128'(1));
    chk("in_en_pre_rst", 128'(bus.input_rd_en), 128'(2'b11));
    nRST = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    run_op(1, 0, 0, 0, 0, 3'b010, 3'b001, 16'h3C3C, 16'h7E7E);

    // Full depth, with a write in the start cycle
    for (int a = 0; a < DEPTH; a++) begin
      for (int r = 0; r < N; r++) wr_i(r, a, $urandom);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) wr_w(r, c, a, $urandom);
    end
    run_op(DEPTH, 0, 0, 0, 1, 3'b011, 3'b000, 16'h9876, 16'h1357);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
